// File: rtl/time_nmr_pkg.sv
// Shared types and helpers for the time-redundant pipeline end stage.
package time_nmr_pkg;

  typedef enum logic {
    StCollect,
    StOutput
  } nmr_state_e;

  function automatic int majority_threshold(int r);
    return (r + 1) / 2;
  endfunction

  function automatic bit redundancy_legal(int r);
    return (r == 3) || (r == 5);
  endfunction

  function automatic bit lock_timeout_legal(int t);
    return t >= 1;
  endfunction

endpackage

// File: rtl/time_nmr_voter.sv
// Combinational N-way majority voter over {id, data} tuples with a per-entry valid mask.
module time_nmr_voter
  import time_nmr_pkg::*;
#(
  parameter int unsigned Redundancy = 3,
  parameter int unsigned TupleWidth = 13
) (
  input  logic [Redundancy-1:0][TupleWidth-1:0] tuples_i,
  input  logic [Redundancy-1:0]                 valid_i,
  output logic [TupleWidth-1:0]                 tuple_o,
  output logic                                  majority_o,
  output logic                                  unanimous_o
);

  localparam int unsigned CntW   = $clog2(Redundancy + 1);
  localparam int unsigned Thresh = majority_threshold(Redundancy);

  logic [CntW-1:0] w_cnt;
  logic [CntW-1:0] w_best_cnt;
  logic [CntW-1:0] w_valid_cnt;

  always_comb begin
    tuple_o     = '0;
    w_cnt       = '0;
    w_best_cnt  = '0;
    w_valid_cnt = '0;
    for (int i = 0; i < Redundancy; i++) begin
      w_cnt = '0;
      if (valid_i[i]) begin
        w_valid_cnt = w_valid_cnt + 1'b1;
        for (int j = 0; j < Redundancy; j++) begin
          if (valid_i[j] && (tuples_i[j] == tuples_i[i])) begin
            w_cnt = w_cnt + 1'b1;
          end
        end
        if (w_cnt > w_best_cnt) begin
          w_best_cnt = w_cnt;
          tuple_o    = tuples_i[i];
        end
      end
    end
    majority_o  = (w_best_cnt >= CntW'(Thresh));
    unanimous_o = (w_valid_cnt != '0) && (w_best_cnt == w_valid_cnt);
  end

endmodule

// File: rtl/time_nmr_end.sv
// Output stage of a time-redundant pipeline: buffers Redundancy copies, votes, emits one result.
// Optional macro TIME_NMR_EARLY_VALID_EN emits as soon as a majority is reached.
module time_nmr_end
  import time_nmr_pkg::*;
#(
  parameter int unsigned DataWidth   = 8,
  parameter int unsigned IDSize      = 5,
  parameter int unsigned Redundancy  = 3,
  parameter int unsigned LockTimeout = 60
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 enable_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic [IDSize-1:0]    id_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [DataWidth-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 lock_o,
  output logic                 fault_detected_o,
  output logic                 timeout_o
);

  localparam int unsigned TupleW = IDSize + DataWidth;
  localparam int unsigned CntW   = $clog2(Redundancy + 1);
  localparam int unsigned TmoW   = $clog2(LockTimeout + 1);

  if (!redundancy_legal(Redundancy)) begin : g_bad_redundancy
    $error("time_nmr_end: Redundancy must be 3 or 5");
  end
  if (!lock_timeout_legal(LockTimeout)) begin : g_bad_timeout
    $error("time_nmr_end: LockTimeout must be at least 1");
  end

  nmr_state_e                         r_state;
  logic [CntW-1:0]                    r_count;
  logic [Redundancy-1:0][TupleW-1:0]  r_buf;
  logic [IDSize-1:0]                  r_last_id;
  logic                               r_last_vld;
  logic [DataWidth-1:0]               r_data_o;
  logic                               r_fault;
  logic                               r_timeout;
  logic [TmoW-1:0]                    r_tmo_cnt;

  logic                               w_dup;
  logic                               w_lock;
  logic [CntW-1:0]                    w_cnt_next;
  logic [Redundancy-1:0][TupleW-1:0]  w_buf_next;
  logic [Redundancy-1:0]              w_mask_next;
  logic [TupleW-1:0]                  w_win;
  logic                               w_majority;
  logic                               w_unanimous;
  logic                               w_complete;

  assign w_dup      = r_last_vld && (id_i == r_last_id);
  assign w_lock     = (r_state == StCollect) && (r_count != '0);
  assign w_cnt_next = r_count + 1'b1;

  // Vote on the buffer as it will look once the incoming copy is stored.
  always_comb begin
    w_buf_next  = r_buf;
    w_mask_next = '0;
    if (r_count < CntW'(Redundancy)) begin
      w_buf_next[r_count] = {id_i, data_i};
    end
    for (int i = 0; i < Redundancy; i++) begin
      w_mask_next[i] = (CntW'(i) < w_cnt_next);
    end
  end

  time_nmr_voter #(
    .Redundancy (Redundancy),
    .TupleWidth (TupleW)
  ) u_voter (
    .tuples_i    (w_buf_next),
    .valid_i     (w_mask_next),
    .tuple_o     (w_win),
    .majority_o  (w_majority),
    .unanimous_o (w_unanimous)
  );

`ifdef TIME_NMR_EARLY_VALID_EN
  assign w_complete = w_majority || (w_cnt_next == CntW'(Redundancy));
`else
  assign w_complete = (w_cnt_next == CntW'(Redundancy));
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i || !enable_i) begin
      r_state    <= StCollect;
      r_count    <= '0;
      r_buf      <= '0;
      r_last_id  <= '0;
      r_last_vld <= 1'b0;
      r_data_o   <= '0;
      r_fault    <= 1'b0;
      r_timeout  <= 1'b0;
      r_tmo_cnt  <= '0;
    end else begin
      r_fault   <= 1'b0;
      r_timeout <= 1'b0;
      unique case (r_state)
        StOutput: begin
          r_tmo_cnt <= '0;
          if (ready_i) begin
            r_state <= StCollect;
            r_count <= '0;
          end
        end
        StCollect: begin
          if (valid_i) begin
            r_tmo_cnt <= '0;
            if (!w_dup) begin
              if (!w_complete) begin
                r_buf   <= w_buf_next;
                r_count <= w_cnt_next;
              end else if (w_majority) begin
                r_buf      <= w_buf_next;
                r_count    <= w_cnt_next;
                r_state    <= StOutput;
                r_data_o   <= w_win[DataWidth-1:0];
                r_last_id  <= w_win[TupleW-1:DataWidth];
                r_last_vld <= 1'b1;
                r_fault    <= !w_unanimous;
              end else begin
                r_count <= '0;
                r_fault <= 1'b1;
              end
            end
          end else if (w_lock) begin
            if (r_tmo_cnt == TmoW'(LockTimeout - 1)) begin
              r_count   <= '0;
              r_tmo_cnt <= '0;
              r_fault   <= 1'b1;
              r_timeout <= 1'b1;
            end else begin
              r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
          end else begin
            r_tmo_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if (enable_i) begin
      data_o           = r_data_o;
      valid_o          = (r_state == StOutput);
      ready_o          = !rst_i && (r_state == StCollect);
      lock_o           = w_lock;
      fault_detected_o = r_fault;
      timeout_o        = r_timeout;
    end else begin
      data_o           = data_i;
      valid_o          = valid_i;
      ready_o          = ready_i;
      lock_o           = 1'b0;
      fault_detected_o = 1'b0;
      timeout_o        = 1'b0;
    end
  end

endmodule

// File: tb/tb_time_nmr_end.sv
// Bench for time_nmr_end: a 3-way and a 5-way instance checked every cycle against a group model.
module tb_time_nmr_end;

  localparam int LT = 8;
`ifdef TIME_NMR_EARLY_VALID_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       en   [2];
  logic       vi   [2];
  logic       ri   [2];
  logic [7:0] din  [2];
  logic [4:0] idin [2];
  logic [7:0] dout [2];
  logic       vo   [2];
  logic       ro   [2];
  logic       lk   [2];
  logic       fl   [2];
  logic       to   [2];

  int n_pass  = 0;
  int n_total = 0;

  // Model state per instance: the group collected so far plus pending output.
  logic [12:0] m_grp [2][5];
  int          m_r   [2];
  int          m_n   [2];
  bit          m_last_vld [2];
  logic [4:0]  m_last_id  [2];
  bit          m_pend  [2];
  logic [7:0]  m_out   [2];
  int          m_idle  [2];
  bit          m_fault [2];
  bit          m_tmo   [2];

  time_nmr_end #(
    .DataWidth(8), .IDSize(5), .Redundancy(3), .LockTimeout(LT)
  ) u_dut3 (
    .clk_i(clk), .rst_i(rst), .enable_i(en[0]), .data_i(din[0]), .id_i(idin[0]),
    .valid_i(vi[0]), .ready_o(ro[0]), .data_o(dout[0]), .valid_o(vo[0]), .ready_i(ri[0]),
    .lock_o(lk[0]), .fault_detected_o(fl[0]), .timeout_o(to[0])
  );

  time_nmr_end #(
    .DataWidth(8), .IDSize(5), .Redundancy(5), .LockTimeout(LT)
  ) u_dut5 (
    .clk_i(clk), .rst_i(rst), .enable_i(en[1]), .data_i(din[1]), .id_i(idin[1]),
    .valid_i(vi[1]), .ready_o(ro[1]), .data_o(dout[1]), .valid_o(vo[1]), .ready_i(ri[1]),
    .lock_o(lk[1]), .fault_detected_o(fl[1]), .timeout_o(to[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, int k, logic [7:0] got, logic [7:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s[dut%0d] got=%0h exp=%0h", tag, k, got, exp);
  endtask

  task automatic model_clear(int k);
    m_n[k] = 0; m_last_vld[k] = 0; m_last_id[k] = '0; m_pend[k] = 0;
    m_out[k] = '0; m_idle[k] = 0; m_fault[k] = 0; m_tmo[k] = 0;
  endtask

  task automatic check_outputs(int k);
    if (!en[k]) begin
      chk("data_o", k, dout[k], din[k]);
      chk("valid_o", k, 8'(vo[k]), 8'(vi[k]));
      chk("ready_o", k, 8'(ro[k]), 8'(ri[k]));
      chk("lock_o", k, 8'(lk[k]), 8'd0);
      chk("fault_o", k, 8'(fl[k]), 8'd0);
      chk("timeout_o", k, 8'(to[k]), 8'd0);
    end else begin
      chk("data_o", k, dout[k], m_out[k]);
      chk("valid_o", k, 8'(vo[k]), 8'(m_pend[k]));
      chk("ready_o", k, 8'(ro[k]), 8'(!rst && !m_pend[k]));
      chk("lock_o", k, 8'(lk[k]), 8'(!m_pend[k] && m_n[k] > 0));
      chk("fault_o", k, 8'(fl[k]), 8'(m_fault[k]));
      chk("timeout_o", k, 8'(to[k]), 8'(m_tmo[k]));
    end
  endtask

  task automatic model_edge(int k);
    int best;
    int c;
    logic [12:0] bt;
    bit done;
    if (rst || !en[k]) begin
      model_clear(k);
    end else begin
      m_fault[k] = 0;
      m_tmo[k]   = 0;
      if (m_pend[k]) begin
        m_idle[k] = 0;
        if (ri[k]) begin
          m_pend[k] = 0;
          m_n[k]    = 0;
        end
      end else if (vi[k]) begin
        m_idle[k] = 0;
        if (!(m_last_vld[k] && idin[k] == m_last_id[k])) begin
          m_grp[k][m_n[k]] = {idin[k], din[k]};
          m_n[k]++;
          best = 0;
          bt   = '0;
          for (int i = 0; i < m_n[k]; i++) begin
            c = 0;
            for (int j = 0; j < m_n[k]; j++) if (m_grp[k][j] == m_grp[k][i]) c++;
            if (c > best) begin
              best = c;
              bt   = m_grp[k][i];
            end
          end
          done = (m_n[k] == m_r[k]) || (Early && best >= (m_r[k] + 1) / 2);
          if (done) begin
            if (best >= (m_r[k] + 1) / 2) begin
              m_pend[k]     = 1;
              m_out[k]      = bt[7:0];
              m_last_id[k]  = bt[12:8];
              m_last_vld[k] = 1;
              m_fault[k]    = (best < m_n[k]);
            end else begin
              m_fault[k] = 1;
              m_n[k]     = 0;
            end
          end
        end
      end else if (m_n[k] > 0) begin
        m_idle[k]++;
        if (m_idle[k] == LT) begin
          m_n[k] = 0; m_idle[k] = 0; m_fault[k] = 1; m_tmo[k] = 1;
        end
      end else begin
        m_idle[k] = 0;
      end
    end
  endtask

  // Called just after a negedge with inputs already driven; returns just after the next negedge.
  task automatic tick(bit do_chk);
    #1;
    if (do_chk) begin
      check_outputs(0);
      check_outputs(1);
    end
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    @(negedge clk);
  endtask

  task automatic send(int k, logic [4:0] id, logic [7:0] d);
    bit hs;
    int guard;
    vi[k] = 1'b1; idin[k] = id; din[k] = d;
    guard = 0;
    do begin
      hs = !m_pend[k];
      tick(1);
      guard++;
    end while (!hs && guard < 20);
    if (!hs) chk("send_timeout", k, 8'd0, 8'd1);
    vi[k] = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) tick(1);
  endtask

  initial begin
    m_r[0] = 3;
    m_r[1] = 5;
    for (int k = 0; k < 2; k++) begin
      model_clear(k);
      en[k] = 1'b1; vi[k] = 1'b0; ri[k] = 1'b1; din[k] = '0; idin[k] = '0;
    end
    rst = 1'b1;
    @(negedge clk);
    tick(0);
    idle(2);
    rst = 1'b0;
    idle(1);

    // Bypass
    en[0] = 1'b0; vi[0] = 1'b1; din[0] = 8'hA5; idin[0] = 5'd3;
    idle(2);
    vi[0] = 1'b0; en[0] = 1'b1;
    idle(1);

    // Clean group, then a swallowed late duplicate
    repeat (3) send(0, 5'd4, 8'h3C);
    idle(2);
    send(0, 5'd4, 8'h3C);
    idle(2);

    // One corrupted copy out of five
    send(1, 5'd6, 8'h11); send(1, 5'd6, 8'h11); send(1, 5'd6, 8'h7F);
    send(1, 5'd6, 8'h11); send(1, 5'd6, 8'h11);
    idle(3);

    // No majority
    send(0, 5'd7, 8'h01); send(0, 5'd7, 8'h02); send(0, 5'd7, 8'h03);
    idle(3);

    // Lock timeout, then a normal group with output backpressure
    send(0, 5'd9, 8'hAA);
    idle(12);
    ri[0] = 1'b0;
    repeat (3) send(0, 5'd9, 8'hBB);
    idle(3);
    ri[0] = 1'b1;
    idle(2);

    // Handshake in the timeout cycle
    send(0, 5'd11, 8'h42);
    idle(LT - 1);
    send(0, 5'd11, 8'h42);
    send(0, 5'd11, 8'h42);
    idle(3);

    // Enable toggled mid-group
    send(1, 5'd12, 8'h99); send(1, 5'd12, 8'h99);
    en[1] = 1'b0;
    idle(1);
    en[1] = 1'b1;
    repeat (5) send(1, 5'd12, 8'h98);
    idle(3);

    // Randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int k = 0; k < 2; k++) begin
        en[k]   = ($urandom_range(0, 39) != 0);
        vi[k]   = ((cyc % 150) < 15) ? 1'b0 : ($urandom_range(0, 2) != 0);
        ri[k]   = ($urandom_range(0, 3) != 0);
        idin[k] = 5'($urandom_range(0, 3));
        din[k]  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255))
                                               : 8'h5A + 8'(idin[k]);
      end
      tick(1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
